uart_rx_ctrl: RTL and testbench

Receive-side sequencer for the UART receiver datapath. It synchronises the serial line and generates 16x-oversampled bit timing. A state machine samples start, data, parity and stop bits at bit centre, and emits the shift/parity_load/check_stop strobes used by the receive shift/check logic. It also assembles its own byte and delivers it through a valid/ready handshake with parity, framing and overrun status.

---
 rtl/uart_rx_ctrl_pkg.sv | 33 +++
 rtl/uart_rx_ctrl_if.sv | 37 +++
 rtl/uart_baud_tick.sv | 40 ++++
 rtl/uart_rx_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// uart_rx_ctrl_pkg
// Shared definitions for the UART receive sequencer: FSM state encoding,
// oversampling constants and the bit-centre offsets used when sampling, plus
// the parity-check helper.
// -----------------------------------------------------------------------------
package uart_rx_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam int OVERSAMPLE = 16;
  localparam int OS_W       = $clog2(OVERSAMPLE);

  // Start bit is qualified at its centre; every later bit is sampled one full
  // bit period after the previous centre, i.e. when os wraps back to zero.
  localparam logic [OS_W-1:0] START_MID = OS_W'(7);
  localparam logic [OS_W-1:0] BIT_END   = OS_W'(OVERSAMPLE - 1);

  // High when the received parity bit does not match the expected sense.
  // data_xor is the XOR-reduction of the received data bits.
  function automatic logic parity_mismatch(input logic data_xor,
                                           input logic parity_bit,
                                           input logic odd);
    return ((data_xor ^ parity_bit) != odd);
  endfunction

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// -----------------------------------------------------------------------------
// uart_rx_ctrl_if
// Valid/ready delivery channel for received bytes with per-byte status.
//   rx_data      received byte, stable while rx_valid=1
//   rx_valid     byte available, held until accepted
//   rx_ready     consumer accepts on a clk edge with rx_valid & rx_ready
//   parity_error parity status of the byte in rx_data
//   stop_error   framing status of the byte in rx_data
// master = receiver (producer), slave = consumer.
// -----------------------------------------------------------------------------
interface uart_rx_ctrl_if #(
  parameter int DATA_BITS = 8
);

  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 parity_error;
  logic                 stop_error;

  modport master (
    output rx_data,
    output rx_valid,
    output parity_error,
    output stop_error,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    input  parity_error,
    input  stop_error,
    output rx_ready
  );

endinterface

// File: rtl/uart_baud_tick.sv
// -----------------------------------------------------------------------------
// uart_baud_tick
// Oversample tick generator: counts 0..CLKS_PER_TICK-1 and flags the terminal
// count. Held at zero while clear is high so the first tick after clear falls
// exactly CLKS_PER_TICK clocks later.
//   clk    system clock
//   reset  synchronous, active-low reset
//   clear  synchronous clear (held while the receiver is idle)
//   tick   high for one clk on each terminal count
// -----------------------------------------------------------------------------
module uart_baud_tick #(
  parameter int CLKS_PER_TICK = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_TICK - 1);

  logic [CNT_W-1:0] cnt;

  // Divider counter, wraps on terminal count.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= CNT_W'(0);
    end else if (clear) begin
      cnt <= CNT_W'(0);
    end else if (cnt == LAST) begin
      cnt <= CNT_W'(0);
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tick = !clear && (cnt == LAST);

endmodule

// File: rtl/uart_rx_ctrl.sv
// -----------------------------------------------------------------------------
// uart_rx_ctrl
// UART receive sequencer. Synchronises the serial line, times bits with 16x
// oversampling, samples start/data/parity/stop at bit centre, strobes the
// downstream shift/check logic and delivers its own assembled byte through a
// valid/ready channel with parity, framing and overrun status.
//   clk          system clock
//   reset        synchronous, active-low reset
//   rx_in        asynchronous serial line, idle high
//   bus          delivery channel (rx_data/rx_valid/rx_ready/status)
//   overrun      one-cycle pulse: frame completed while rx_valid still high
//   busy         high in any state other than IDLE
//   shift        one-cycle strobe after each data-bit centre sample
//   parity_load  one-cycle strobe after the parity-bit centre sample
//   check_stop   one-cycle strobe after the stop-bit centre sample
// -----------------------------------------------------------------------------
module uart_rx_ctrl
  import uart_rx_ctrl_pkg::*;
#(
  parameter int CLKS_PER_TICK = 8,
  parameter int DATA_BITS     = 8,
  parameter int PARITY_EN     = 1,
  parameter int PARITY_ODD    = 0
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           rx_in,
  uart_rx_ctrl_if.master bus,
  output logic           overrun,
  output logic           busy,
  output logic           shift,
  output logic           parity_load,
  output logic           check_stop
);

  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);
  localparam logic PAR_EN  = (PARITY_EN != 0);
  localparam logic PAR_ODD = (PARITY_ODD != 0);

  logic                 sync1;
  logic                 rxs;
  state_t               state;
  state_t               next_state;
  logic                 tick;
  logic                 tick_clear;
  logic [OS_W-1:0]      os;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] sreg;
  logic                 par_err;
  logic                 stop_err;
  logic                 start_mid;
  logic                 bit_end;
  logic                 shift_nxt;
  logic                 parity_load_nxt;
  logic                 check_stop_nxt;
  logic                 busy_nxt;

  // The tick divider only runs while a frame is in progress so that bit
  // timing is phase-locked to the detected start edge.
  assign tick_clear = (state == IDLE);

  uart_baud_tick #(
    .CLKS_PER_TICK (CLKS_PER_TICK)
  ) u_baud_tick (
    .clk   (clk),
    .reset (reset),
    .clear (tick_clear),
    .tick  (tick)
  );

  assign start_mid = tick && (os == START_MID);
  assign bit_end   = tick && (os == BIT_END);

  // Two-flop synchroniser; resets to the idle line level.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= rx_in;
      rxs   <= sync1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // FSM next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (!rxs) next_state = START;
        else      next_state = IDLE;
      end
      START: begin
        // A line that is high again at start centre was a glitch.
        if (start_mid) next_state = rxs ? IDLE : DATA;
        else           next_state = START;
      end
      DATA: begin
        if (bit_end && (bit_idx == LAST_IDX)) next_state = PAR_EN ? PARITY : STOP;
        else                                  next_state = DATA;
      end
      PARITY: begin
        if (bit_end) next_state = STOP;
        else         next_state = PARITY;
      end
      STOP: begin
        // Leave at stop centre so a new start edge in the second half of the
        // stop bit is not missed.
        if (bit_end) next_state = IDLE;
        else         next_state = STOP;
      end
      default: next_state = IDLE;
    endcase
  end

  // FSM output decode; registered below so every strobe is a clean flop.
  always_comb begin
    shift_nxt       = 1'b0;
    parity_load_nxt = 1'b0;
    check_stop_nxt  = 1'b0;
    case (state)
      DATA:    shift_nxt       = bit_end;
      PARITY:  parity_load_nxt = bit_end;
      STOP:    check_stop_nxt  = bit_end;
      default: shift_nxt       = 1'b0;
    endcase
    busy_nxt = (next_state != IDLE);
  end

  // Oversample position and data bit index.
  always_ff @(posedge clk) begin
    if (!reset) begin
      os      <= OS_W'(0);
      bit_idx <= IDX_W'(0);
    end else begin
      case (state)
        IDLE: begin
          os      <= OS_W'(0);
          bit_idx <= IDX_W'(0);
        end
        START: begin
          // Re-zero at start centre: later centres then land on os wrap.
          if (tick) os <= start_mid ? OS_W'(0) : (os + OS_W'(1));
        end
        DATA: begin
          if (tick) os <= os + OS_W'(1);
          if (bit_end) bit_idx <= bit_idx + IDX_W'(1);
        end
        default: begin
          if (tick) os <= os + OS_W'(1);
        end
      endcase
    end
  end

  // Byte assembly (LSB first into the MSB end) and per-frame status.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sreg     <= {DATA_BITS{1'b0}};
      par_err  <= 1'b0;
      stop_err <= 1'b0;
    end else begin
      if ((state == DATA) && bit_end) sreg <= {rxs, sreg[DATA_BITS-1:1]};
      if ((state == IDLE) && !rxs) begin
        par_err <= 1'b0;
      end else if ((state == PARITY) && bit_end) begin
        par_err <= PAR_EN && parity_mismatch(^sreg, rxs, PAR_ODD);
      end
      if ((state == STOP) && bit_end) stop_err <= ~rxs;
    end
  end

  // Registered strobes and busy flag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      shift       <= 1'b0;
      parity_load <= 1'b0;
      check_stop  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      shift       <= shift_nxt;
      parity_load <= parity_load_nxt;
      check_stop  <= check_stop_nxt;
      busy        <= busy_nxt;
    end
  end

  // Delivery: check_stop marks the cycle after the stop sample, so the frame
  // is handed over (or dropped as an overrun) one clock after the strobe.
  always_ff @(posedge clk) begin
    if (!reset) begin
      bus.rx_data      <= {DATA_BITS{1'b0}};
      bus.rx_valid     <= 1'b0;
      bus.parity_error <= 1'b0;
      bus.stop_error   <= 1'b0;
      overrun          <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (check_stop) begin
        if (!bus.rx_valid || bus.rx_ready) begin
          bus.rx_data      <= sreg;
          bus.parity_error <= par_err;
          bus.stop_error   <= stop_err;
          bus.rx_valid     <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (bus.rx_valid && bus.rx_ready) begin
        bus.rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_ctrl
// Self-checking bench for uart_rx_ctrl at 16 clk per bit, even parity.
// Expected bytes are queued when a frame is driven; a monitor queues every
// byte accepted on the valid/ready channel and the test tasks pair them up.
// -----------------------------------------------------------------------------
module tb_uart_rx_ctrl;

  typedef logic [9:0] rec_t; // {data, parity_error, stop_error}

  logic clk;
  logic reset;
  logic rx_in;
  logic overrun, busy, shift, parity_load, check_stop;

  uart_rx_ctrl_if #(.DATA_BITS(8)) bus ();

  uart_rx_ctrl #(
    .CLKS_PER_TICK (1),
    .DATA_BITS     (8),
    .PARITY_EN     (1),
    .PARITY_ODD    (0)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_in       (rx_in),
    .bus         (bus),
    .overrun     (overrun),
    .busy        (busy),
    .shift       (shift),
    .parity_load (parity_load),
    .check_stop  (check_stop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  rec_t exp_q[$];
  rec_t obs_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  int   cyc = 0;
  int   shift_cnt = 0, pl_cnt = 0, cs_cnt = 0, ov_cnt = 0, busy_cnt = 0;
  int   gap_bad = 0, excl_bad = 0, last_shift = -1;
  int   cs_cyc = 0, rv_rise_cyc = 0;
  logic prev_valid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: samples mid-low-phase, records handshakes and strobe activity.
  always begin
    @(negedge clk);
    #2;
    if (bus.rx_valid && bus.rx_ready)
      obs_q.push_back({bus.rx_data, bus.parity_error, bus.stop_error});
    if (bus.rx_valid && !prev_valid) rv_rise_cyc = cyc;
    prev_valid = bus.rx_valid;
    if (shift) begin
      if (last_shift >= 0 && (cyc - last_shift) != 16) gap_bad++;
      last_shift = cyc;
      shift_cnt++;
    end
    if (parity_load) pl_cnt++;
    if (check_stop) begin cs_cnt++; cs_cyc = cyc; end
    if (check_stop || !reset) last_shift = -1;
    if (overrun) ov_cnt++;
    if (busy) busy_cnt++;
    if ((int'(shift) + int'(parity_load) + int'(check_stop)) > 1) excl_bad++;
  end

  // Even parity: error when the total number of ones (data + parity) is odd.
  function automatic logic model_perr(input logic [7:0] d, input logic p);
    int ones;
    ones = int'(p);
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    return (ones % 2) != 0;
  endfunction

  task automatic line(input logic b, input int n);
    rx_in = b;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s,
                            input int stop_len, input bit push);
    if (push) exp_q.push_back({d, model_perr(d, p), ~s});
    line(1'b0, 16);
    for (int i = 0; i < 8; i++) line(d[i], 16);
    line(p, 16);
    line(s, stop_len);
    rx_in = 1'b1;
  endtask

  task automatic wait_obs(input int n, input int max_cyc, output bit ok);
    int i;
    i = 0;
    while (obs_q.size() < n && i < max_cyc) begin
      @(negedge clk);
      i++;
    end
    ok = (obs_q.size() >= n);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    rx_in = 1'b1;
    bus.rx_ready = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({bus.rx_valid, bus.rx_data, bus.parity_error, bus.stop_error} !== 11'd0) begin
      n_bad++;
      $display("FAIL reset_bus: got %h want 0", {bus.rx_valid, bus.rx_data, bus.parity_error, bus.stop_error});
    end
    n_cmp++;
    if ({overrun, busy, shift, parity_load, check_stop} !== 5'd0) begin
      n_bad++;
      $display("FAIL reset_ctl: got %b want 00000", {overrun, busy, shift, parity_load, check_stop});
    end
    reset = 1'b1;
    repeat (5) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_basic();
    int s0, p0, c0, g0;
    bit ok;
    rec_t e, o;
    s0 = shift_cnt; p0 = pl_cnt; c0 = cs_cnt; g0 = gap_bad;
    send_frame(8'hA5, 1'b0, 1'b1, 16, 1'b1);
    line(1'b1, 4);
    wait_obs(1, 40, ok);
    n_cmp++;
    if (!ok) begin
      n_bad++; $display("FAIL basic_timeout: got no byte want 1 byte");
    end else begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      if (o !== e) begin n_bad++; $display("FAIL basic_byte: got %h want %h", o, e); end
    end
    n_cmp++;
    if (shift_cnt - s0 !== 8) begin n_bad++; $display("FAIL basic_shifts: got %0d want 8", shift_cnt - s0); end
    n_cmp++;
    if (gap_bad !== g0) begin n_bad++; $display("FAIL basic_shift_gap: got %0d bad gaps want 0", gap_bad - g0); end
    n_cmp++;
    if (pl_cnt - p0 !== 1) begin n_bad++; $display("FAIL basic_parity_load: got %0d want 1", pl_cnt - p0); end
    n_cmp++;
    if (cs_cnt - c0 !== 1) begin n_bad++; $display("FAIL basic_check_stop: got %0d want 1", cs_cnt - c0); end
    n_cmp++;
    if (rv_rise_cyc - cs_cyc !== 1) begin
      n_bad++; $display("FAIL basic_latency: got %0d want 1", rv_rise_cyc - cs_cyc);
    end
  endtask

  task automatic test_errors();
    bit ok;
    rec_t e, o;
    send_frame(8'h3C, 1'b1, 1'b1, 16, 1'b1);
    send_frame(8'h01, 1'b1, 1'b0, 16, 1'b1);
    line(1'b1, 30);
    wait_obs(2, 40, ok);
    n_cmp++;
    if (!ok) begin
      n_bad++; $display("FAIL errors_timeout: got %0d bytes want 2", obs_q.size());
    end else begin
      for (int k = 0; k < 2; k++) begin
        e = exp_q.pop_front(); o = obs_q.pop_front();
        n_cmp++;
        if (o !== e) begin n_bad++; $display("FAIL errors_byte%0d: got %h want %h", k, o, e); end
      end
    end
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL errors_idle: got busy=%b want 0", busy); end
  endtask

  task automatic test_glitch();
    int s0, p0, c0, b0;
    s0 = shift_cnt; p0 = pl_cnt; c0 = cs_cnt; b0 = busy_cnt;
    line(1'b0, 4);
    line(1'b1, 30);
    n_cmp++;
    if (busy_cnt - b0 !== 8) begin n_bad++; $display("FAIL glitch_busy_cycles: got %0d want 8", busy_cnt - b0); end
    n_cmp++;
    if ((shift_cnt - s0) + (pl_cnt - p0) + (cs_cnt - c0) !== 0) begin
      n_bad++; $display("FAIL glitch_strobes: got %0d want 0", (shift_cnt - s0) + (pl_cnt - p0) + (cs_cnt - c0));
    end
    n_cmp++;
    if (bus.rx_valid !== 1'b0 || obs_q.size() !== 0) begin
      n_bad++; $display("FAIL glitch_valid: got valid=%b bytes=%0d want 0/0", bus.rx_valid, obs_q.size());
    end
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL glitch_busy: got %b want 0", busy); end
  endtask

  task automatic test_overrun();
    int v0;
    bit ok;
    rec_t e, o;
    v0 = ov_cnt;
    bus.rx_ready = 1'b0;
    send_frame(8'h11, 1'b0, 1'b1, 16, 1'b1);
    send_frame(8'h22, 1'b0, 1'b1, 16, 1'b0);
    line(1'b1, 4);
    n_cmp++;
    if (ov_cnt - v0 !== 1) begin n_bad++; $display("FAIL overrun_pulses: got %0d want 1", ov_cnt - v0); end
    n_cmp++;
    if (bus.rx_valid !== 1'b1) begin n_bad++; $display("FAIL overrun_valid: got %b want 1", bus.rx_valid); end
    n_cmp++;
    if (bus.rx_data !== 8'h11) begin n_bad++; $display("FAIL overrun_hold: got %h want 11", bus.rx_data); end
    bus.rx_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus.rx_valid !== 1'b0) begin n_bad++; $display("FAIL overrun_accept: got valid=%b want 0", bus.rx_valid); end
    wait_obs(1, 4, ok);
    n_cmp++;
    if (!ok) begin
      n_bad++; $display("FAIL overrun_timeout: got no byte want 1 byte");
    end else begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      if (o !== e) begin n_bad++; $display("FAIL overrun_byte: got %h want %h", o, e); end
    end
  endtask

  task automatic test_reset_midframe();
    int s0;
    bit ok;
    rec_t e, o;
    s0 = shift_cnt;
    line(1'b0, 16);
    line(1'b1, 16);
    line(1'b0, 16);
    line(1'b1, 16);
    n_cmp++;
    if (shift_cnt - s0 !== 3) begin n_bad++; $display("FAIL midreset_pre_shifts: got %0d want 3", shift_cnt - s0); end
    reset = 1'b0;
    rx_in = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({bus.rx_valid, bus.rx_data, bus.parity_error, bus.stop_error,
         overrun, busy, shift, parity_load, check_stop} !== 16'd0) begin
      n_bad++;
      $display("FAIL midreset_outputs: got %h want 0", {bus.rx_valid, bus.rx_data, bus.parity_error,
               bus.stop_error, overrun, busy, shift, parity_load, check_stop});
    end
    reset = 1'b1;
    line(1'b1, 20);
    n_cmp++;
    if (busy !== 1'b0 || obs_q.size() !== 0) begin
      n_bad++; $display("FAIL midreset_abandon: got busy=%b bytes=%0d want 0/0", busy, obs_q.size());
    end
    send_frame(8'h5A, 1'b0, 1'b1, 16, 1'b1);
    line(1'b1, 4);
    wait_obs(1, 40, ok);
    n_cmp++;
    if (!ok) begin
      n_bad++; $display("FAIL midreset_timeout: got no byte want 1 byte");
    end else begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      if (o !== e) begin n_bad++; $display("FAIL midreset_byte: got %h want %h", o, e); end
    end
  endtask

  task automatic test_back_to_back();
    int v0;
    bit ok;
    rec_t e, o;
    v0 = ov_cnt;
    // Stop bit stretched by one clk: next start edge lands 9 clk after stop centre.
    send_frame(8'h96, 1'b0, 1'b1, 17, 1'b1);
    send_frame(8'h69, 1'b0, 1'b1, 16, 1'b1);
    line(1'b1, 4);
    wait_obs(2, 40, ok);
    n_cmp++;
    if (!ok) begin
      n_bad++; $display("FAIL b2b_timeout: got %0d bytes want 2", obs_q.size());
    end else begin
      for (int k = 0; k < 2; k++) begin
        e = exp_q.pop_front(); o = obs_q.pop_front();
        n_cmp++;
        if (o !== e) begin n_bad++; $display("FAIL b2b_byte%0d: got %h want %h", k, o, e); end
      end
    end
    n_cmp++;
    if (ov_cnt - v0 !== 0) begin n_bad++; $display("FAIL b2b_overrun: got %0d want 0", ov_cnt - v0); end
    n_cmp++;
    if (excl_bad !== 0) begin n_bad++; $display("FAIL strobe_exclusive: got %0d overlaps want 0", excl_bad); end
    n_cmp++;
    if (gap_bad !== 0) begin n_bad++; $display("FAIL shift_spacing: got %0d bad gaps want 0", gap_bad); end
    n_cmp++;
    if (exp_q.size() !== 0 || obs_q.size() !== 0) begin
      n_bad++; $display("FAIL scoreboard_drain: got exp=%0d obs=%0d want 0/0", exp_q.size(), obs_q.size());
    end
  endtask

  initial begin
    reset = 1'b0;
    rx_in = 1'b1;
    bus.rx_ready = 1'b1;
    @(negedge clk);
    test_reset();
    test_basic();
    test_errors();
    test_glitch();
    test_overrun();
    test_reset_midframe();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
